// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the line, validates the start bit, samples each bit at its centre
// and holds the byte in a one-entry valid/ready buffer with framing-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_frame_err;
    logic        r_busy;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_overrun;

    logic w_rxd_s;
    logic w_bit_end;
    logic w_load;

    assign w_rxd_s   = r_sync2;
    assign w_bit_end = (r_cnt == BIT_LAST);
    assign w_load    = (r_state == S_STOP) && w_bit_end && w_rxd_s;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Frame FSM: start validation at half a bit, then one sample per bit period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rxd_s) begin
                        r_cnt   <= '0;
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_rxd_s) begin
                            r_bit_idx <= '0;
                            r_state   <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rxd_s;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_rxd_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    // A held-low line (break) parks here instead of producing bytes
                    if (w_rxd_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // One-entry holding buffer; a load with a simultaneous drain is not an overrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                if (r_valid && !rx_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_overrun   = r_overrun;
    assign rx_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: single byte, handshake/overrun,
// framing error with break, glitch, mid-frame reset and transmitter baud skew.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CPB    = 16;
    localparam int unsigned CLK_NS = 10;
    localparam int unsigned BIT_NS = CPB * CLK_NS;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_start = 0;
    int t_rise = 0;
    int n_vcyc = 0;
    int n_fe = 0;
    int n_ov = 0;
    logic prev_v = 1'b0;
    logic [7:0] q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .uart_rxd    (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun),
        .rx_busy     (rx_busy)
    );

    always #(CLK_NS / 2) clk = ~clk;

    always @(posedge clk) cyc++;

    // Observe outputs mid-cycle: accepted bytes, valid cycles and flag pulses
    always @(negedge clk) begin
        if (rx_valid && rx_ready) q.push_back(rx_data);
        if (rx_valid) n_vcyc++;
        if (rx_valid && !prev_v) t_rise = cyc;
        if (rx_frame_err) n_fe++;
        if (rx_overrun) n_ov++;
        prev_v = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] q_at(input int i);
        if (q.size() > i) return q[i];
        return 8'hxx;
    endfunction

    task automatic send_frame(input logic [7:0] b, input int unsigned bit_ns, input logic stop_lvl);
        @(negedge clk);
        t_start = cyc;
        rxd = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(bit_ns);
        end
        rxd = stop_lvl;
        #(bit_ns);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2 rx_ready = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int v0, fe0, ov0;

    initial begin
        // Reset state
        idle(3);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_busy", 32'(rx_busy), 0);
        check("rst_fe", 32'(rx_frame_err), 0);
        check("rst_ov", 32'(rx_overrun), 0);
        @(negedge clk) reset_n = 1'b1;
        idle(5);

        // Single byte with ready held high
        q.delete(); v0 = n_vcyc; fe0 = n_fe; ov0 = n_ov;
        send_frame(8'hA5, BIT_NS, 1'b1);
        idle(20);
        check("a5_count", 32'(q.size()), 1);
        check("a5_data", 32'(q_at(0)), 32'hA5);
        check("a5_vcycles", 32'(n_vcyc - v0), 1);
        check("a5_latency_in_153_155", 32'((t_rise - t_start) >= 153 && (t_rise - t_start) <= 155), 1);
        check("a5_flags", 32'((n_fe - fe0) + (n_ov - ov0)), 0);

        // Byte held until ready pulses
        set_ready(1'b0);
        q.delete();
        send_frame(8'h3C, BIT_NS, 1'b1);
        idle(30);
        check("hold_valid", 32'(rx_valid), 1);
        check("hold_data", 32'(rx_data), 32'h3C);
        set_ready(1'b1);
        set_ready(1'b0);
        @(negedge clk);
        check("drain_valid", 32'(rx_valid), 0);
        check("drain_byte", 32'(q_at(0)), 32'h3C);
        check("drain_data_kept", 32'(rx_data), 32'h3C);

        // Two back-to-back bytes into a full buffer
        ov0 = n_ov;
        send_frame(8'h11, BIT_NS, 1'b1);
        send_frame(8'h22, BIT_NS, 1'b1);
        idle(30);
        check("ovr_pulses", 32'(n_ov - ov0), 1);
        check("ovr_data", 32'(rx_data), 32'h22);
        check("ovr_valid", 32'(rx_valid), 1);
        set_ready(1'b1);
        idle(5);
        check("ovr_drained", 32'(rx_valid), 0);

        // Stop bit low followed by a 40-bit break
        q.delete(); v0 = n_vcyc; fe0 = n_fe;
        send_frame(8'hFF, BIT_NS, 1'b0);
        #(40 * BIT_NS);
        check("brk_fe_pulses", 32'(n_fe - fe0), 1);
        check("brk_no_valid", 32'(n_vcyc - v0), 0);
        check("brk_busy", 32'(rx_busy), 1);
        rxd = 1'b1;
        idle(40);
        check("brk_busy_clear", 32'(rx_busy), 0);
        send_frame(8'h55, BIT_NS, 1'b1);
        idle(20);
        check("post_brk_count", 32'(q.size()), 1);
        check("post_brk_data", 32'(q_at(0)), 32'h55);

        // Short low glitch on an idle line
        v0 = n_vcyc; fe0 = n_fe; ov0 = n_ov;
        @(negedge clk) rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        idle(40);
        check("glitch_busy", 32'(rx_busy), 0);
        check("glitch_no_valid", 32'(n_vcyc - v0), 0);
        check("glitch_flags", 32'((n_fe - fe0) + (n_ov - ov0)), 0);

        // Asynchronous reset during bit 4 of 0x81
        fork
            send_frame(8'h81, BIT_NS, 1'b1);
            begin
                repeat (90) @(posedge clk);
                #3 reset_n = 1'b0;
                #1;
                check("mid_rst_data", 32'(rx_data), 0);
                check("mid_rst_busy", 32'(rx_busy), 0);
                check("mid_rst_valid", 32'(rx_valid), 0);
                check("mid_rst_flags", 32'({rx_frame_err, rx_overrun}), 0);
            end
        join
        idle(5);
        @(negedge clk) reset_n = 1'b1;
        idle(5);
        q.delete();
        send_frame(8'h7E, BIT_NS, 1'b1);
        idle(20);
        check("post_rst_count", 32'(q.size()), 1);
        check("post_rst_data", 32'(q_at(0)), 32'h7E);

        // Transmitter about 3% slow and 3% fast
        for (int s = 0; s < 2; s++) begin
            int unsigned bt;
            bt = (s == 0) ? 155 : 165;
            q.delete(); fe0 = n_fe; ov0 = n_ov;
            send_frame(8'h00, bt, 1'b1);
            send_frame(8'hFF, bt, 1'b1);
            send_frame(8'h5A, bt, 1'b1);
            idle(40);
            check($sformatf("skew%0d_count", bt), 32'(q.size()), 3);
            check($sformatf("skew%0d_b0", bt), 32'(q_at(0)), 32'h00);
            check($sformatf("skew%0d_b1", bt), 32'(q_at(1)), 32'hFF);
            check($sformatf("skew%0d_b2", bt), 32'(q_at(2)), 32'h5A);
            check($sformatf("skew%0d_flags", bt), 32'((n_fe - fe0) + (n_ov - ov0)), 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
